// File: rtl/banco_pkg.sv
// Shared types and default widths for the register-bank arbiter.
package banco_pkg;
   localparam int BITS_PALAVRA  = 16;
   localparam int END_REGISTROS = 3;

   typedef enum logic [1:0] {IDLE, ACESSO, RESPOSTA} estado_t;

   function automatic logic [1:0] um_quente(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction
endpackage

// File: rtl/banco_registro.sv
// Register bank (Banco_Registro): write or refresh A/B on the falling clock edge.
module Banco_Registro #(
   parameter int BITS_PALAVRA  = banco_pkg::BITS_PALAVRA,
   parameter int END_REGISTROS = banco_pkg::END_REGISTROS
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     Hab_Escrita,
   input  logic [END_REGISTROS-1:0] Sel_E_SA,
   input  logic [END_REGISTROS-1:0] Sel_SB,
   input  logic [BITS_PALAVRA-1:0]  E,
   output logic [BITS_PALAVRA-1:0]  A,
   output logic [BITS_PALAVRA-1:0]  B
);
   localparam int N_REG = 1 << END_REGISTROS;

   logic [BITS_PALAVRA-1:0] regs [N_REG];

   // A/B are frozen during a write cycle and refreshed otherwise.
   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_REG; i++) regs[i] <= '0;
         A <= '0;
         B <= '0;
      end else if (Hab_Escrita) begin
         regs[Sel_E_SA] <= E;
      end else begin
         A <= regs[Sel_E_SA];
         B <= regs[Sel_SB];
      end
   end
endmodule

// File: rtl/rr_arbitro_2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_arbitro_2 (
   input  logic [1:0] req,
   input  logic       ultimo,
   output logic       vencedor,
   output logic       valido
);
   always_comb begin
      valido   = |req;
      vencedor = 1'b0;
      case (req)
         2'b01:   vencedor = 1'b0;
         2'b10:   vencedor = 1'b1;
         2'b11:   vencedor = ~ultimo;
         default: vencedor = 1'b0;
      endcase
   end
endmodule

// File: rtl/arbitro_banco.sv
// Round-robin arbiter sharing one register bank between the datapath (0) and the debug/load port (1).
module arbitro_banco #(
   parameter int BITS_PALAVRA  = banco_pkg::BITS_PALAVRA,
   parameter int END_REGISTROS = banco_pkg::END_REGISTROS,
   parameter bit PROTEGE_R0    = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [1:0]               req,
   input  logic [1:0]               wr,
   input  logic [END_REGISTROS-1:0] sel_a0,
   input  logic [END_REGISTROS-1:0] sel_a1,
   input  logic [END_REGISTROS-1:0] sel_b0,
   input  logic [END_REGISTROS-1:0] sel_b1,
   input  logic [BITS_PALAVRA-1:0]  wdata0,
   input  logic [BITS_PALAVRA-1:0]  wdata1,
   output logic [1:0]               gnt,
   output logic [1:0]               ack,
   output logic [BITS_PALAVRA-1:0]  rdata_a0,
   output logic [BITS_PALAVRA-1:0]  rdata_b0,
   output logic [BITS_PALAVRA-1:0]  rdata_a1,
   output logic [BITS_PALAVRA-1:0]  rdata_b1,
   output logic                     Hab_Escrita,
   output logic [END_REGISTROS-1:0] Sel_E_SA,
   output logic [END_REGISTROS-1:0] Sel_SB,
   output logic [BITS_PALAVRA-1:0]  E,
   input  logic [BITS_PALAVRA-1:0]  A,
   input  logic [BITS_PALAVRA-1:0]  B
);
   import banco_pkg::*;

   estado_t                  estado_reg;
   logic                     ultimo_reg;
   logic                     vencedor_reg;
   logic                     wr_l_reg;
   logic [END_REGISTROS-1:0] sel_a_l_reg;
   logic [END_REGISTROS-1:0] sel_b_l_reg;
   logic [BITS_PALAVRA-1:0]  wdata_l_reg;

   logic                     vencedor_next;
   logic                     valido;
   logic [BITS_PALAVRA-1:0]  rdata_a_reg [2];
   logic [BITS_PALAVRA-1:0]  rdata_b_reg [2];
   logic                     escrita_r0;

   rr_arbitro_2 u_rr (
      .req      (req),
      .ultimo   (ultimo_reg),
      .vencedor (vencedor_next),
      .valido   (valido)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_reg   <= IDLE;
         ultimo_reg   <= 1'b1;
         vencedor_reg <= 1'b0;
         wr_l_reg     <= 1'b0;
         sel_a_l_reg  <= '0;
         sel_b_l_reg  <= '0;
         wdata_l_reg  <= '0;
      end else begin
         case (estado_reg)
            IDLE: begin
               if (valido) begin
                  vencedor_reg <= vencedor_next;
                  ultimo_reg   <= vencedor_next;
                  wr_l_reg     <= wr[vencedor_next];
                  sel_a_l_reg  <= vencedor_next ? sel_a1 : sel_a0;
                  sel_b_l_reg  <= vencedor_next ? sel_b1 : sel_b0;
                  wdata_l_reg  <= vencedor_next ? wdata1 : wdata0;
                  estado_reg   <= ACESSO;
               end
            end
            ACESSO:   estado_reg <= RESPOSTA;
            RESPOSTA: estado_reg <= IDLE;
            default:  estado_reg <= IDLE;
         endcase
      end
   end

   // Read data is captured at the end of ACESSO, after the bank refreshed A/B on the falling edge.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               rdata_a_reg[gi] <= '0;
               rdata_b_reg[gi] <= '0;
            end else if (estado_reg == ACESSO && !wr_l_reg && vencedor_reg == gi[0]) begin
               rdata_a_reg[gi] <= A;
               rdata_b_reg[gi] <= B;
            end
         end
      end
   endgenerate

   assign escrita_r0  = PROTEGE_R0 && (sel_a_l_reg == '0);
   assign Hab_Escrita = (estado_reg == ACESSO) && wr_l_reg && !escrita_r0;
   assign Sel_E_SA    = sel_a_l_reg;
   assign Sel_SB      = sel_b_l_reg;
   assign E           = wdata_l_reg;

   assign gnt = (estado_reg != IDLE)     ? um_quente(vencedor_reg) : 2'b00;
   assign ack = (estado_reg == RESPOSTA) ? um_quente(vencedor_reg) : 2'b00;

   assign rdata_a0 = rdata_a_reg[0];
   assign rdata_b0 = rdata_b_reg[0];
   assign rdata_a1 = rdata_a_reg[1];
   assign rdata_b1 = rdata_b_reg[1];
endmodule

// File: tb/tb_arbitro_banco.sv
// Scoreboard bench for arbitro_banco driving a real Banco_Registro.
module tb_arbitro_banco;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        bank_rst = 1'b0;
   logic [1:0]  req_t = 2'b00;
   logic [1:0]  wr_t  = 2'b00;
   logic [2:0]  sel_a_t [2];
   logic [2:0]  sel_b_t [2];
   logic [15:0] wdata_t [2];
   logic [1:0]  gnt, ack;
   logic [15:0] rd_a [2];
   logic [15:0] rd_b [2];
   logic        Hab_Escrita;
   logic [2:0]  Sel_E_SA, Sel_SB;
   logic [15:0] E, A, B;

   int checks = 0;
   int passes = 0;
   logic we_seen = 1'b0;

   logic [32:0] exp_q0 [$];
   logic [32:0] exp_q1 [$];
   int          order_q [$];
   logic [31:0] shadow [2];

   always #5 clock = ~clock;

   arbitro_banco #(.BITS_PALAVRA(16), .END_REGISTROS(3), .PROTEGE_R0(1'b1)) dut (
      .clock(clock), .reset(reset), .req(req_t), .wr(wr_t),
      .sel_a0(sel_a_t[0]), .sel_a1(sel_a_t[1]), .sel_b0(sel_b_t[0]), .sel_b1(sel_b_t[1]),
      .wdata0(wdata_t[0]), .wdata1(wdata_t[1]), .gnt(gnt), .ack(ack),
      .rdata_a0(rd_a[0]), .rdata_b0(rd_b[0]), .rdata_a1(rd_a[1]), .rdata_b1(rd_b[1]),
      .Hab_Escrita(Hab_Escrita), .Sel_E_SA(Sel_E_SA), .Sel_SB(Sel_SB), .E(E), .A(A), .B(B)
   );

   Banco_Registro #(.BITS_PALAVRA(16), .END_REGISTROS(3)) u_banco (
      .clock(clock), .reset(bank_rst), .Hab_Escrita(Hab_Escrita),
      .Sel_E_SA(Sel_E_SA), .Sel_SB(Sel_SB), .E(E), .A(A), .B(B)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
   endtask

   // Monitor: pops the expected requester order and per-requester read data on every ack.
   always @(negedge clock) begin : monitor
      logic [32:0] e;
      int r, o;
      if (Hab_Escrita) we_seen = 1'b1;
      if (!reset) begin
         shadow[0] = 32'h0;
         shadow[1] = 32'h0;
      end else if (ack != 2'b00) begin
         r = ack[1] ? 1 : 0;
         o = 1 - r;
         if (order_q.size() == 0) begin
            chk("unexpected_ack", {126'h0, ack}, 128'h0);
         end else begin
            int er;
            er = order_q.pop_front();
            chk("ack_order", {126'h0, ack}, (er == 1) ? 128'h2 : 128'h1);
            chk("gnt_eq_ack", {126'h0, gnt}, {126'h0, ack});
            if (r == 0 && exp_q0.size() != 0) e = exp_q0.pop_front();
            else if (r == 1 && exp_q1.size() != 0) e = exp_q1.pop_front();
            else e = {1'b0, shadow[r]};
            if (!e[32]) e[31:0] = shadow[r];
            chk($sformatf("rdata%0d", r), {96'h0, rd_a[r], rd_b[r]}, {96'h0, e[31:0]});
            chk($sformatf("rdata%0d_untouched", o), {96'h0, rd_a[o], rd_b[o]}, {96'h0, shadow[o]});
            shadow[r] = e[31:0];
            $display("txn: req%0d %s ack, rdata_a=%h rdata_b=%h", r, e[32] ? "read" : "write", rd_a[r], rd_b[r]);
         end
      end
   end

   task automatic txn(input int r, input int dly, input bit w, input logic [2:0] sa,
                      input logic [2:0] sb, input logic [15:0] wd,
                      input logic [15:0] ea, input logic [15:0] eb, input int lat);
      int cnt;
      bit done;
      @(posedge clock); #1;
      repeat (dly) begin @(posedge clock); #1; end
      if (r == 0) exp_q0.push_back({~w, ea, eb});
      else        exp_q1.push_back({~w, ea, eb});
      wr_t[r] = w; sel_a_t[r] = sa; sel_b_t[r] = sb; wdata_t[r] = wd;
      req_t[r] = 1'b1;
      cnt = 0; done = 1'b0;
      while (!done && cnt < 30) begin
         @(negedge clock);
         cnt++;
         if (ack[r]) done = 1'b1;
      end
      if (!done) begin
         checks++;
         $display("FAIL ack_timeout req%0d: no ack after %0d cycles, expected within %0d", r, cnt, 30);
      end else if (lat != 0) begin
         chk($sformatf("latency%0d", r), cnt, lat);
      end
      @(posedge clock); #1;
      req_t[r] = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         sel_a_t[i] = '0; sel_b_t[i] = '0; wdata_t[i] = '0;
      end
      repeat (2) @(posedge clock);
      #1 reset = 1'b1; bank_rst = 1'b1;

      // Idle after reset: everything at zero.
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("idle_outputs", {37'h0, gnt, ack, Hab_Escrita, Sel_E_SA, Sel_SB, E,
                              rd_a[0], rd_b[0], rd_a[1], rd_b[1]}, 128'h0);
      end

      // Write R3 then read it back.
      we_seen = 1'b0;
      order_q.push_back(0);
      txn(0, 0, 1'b1, 3'd3, 3'd0, 16'h1234, 16'h0, 16'h0, 3);
      chk("write_enable_seen", {127'h0, we_seen}, 128'h1);
      order_q.push_back(0);
      txn(0, 0, 1'b0, 3'd3, 3'd3, 16'h0, 16'h1234, 16'h1234, 3);

      // Simultaneous requests after reset: requester 0 first.
      pulse_reset();
      order_q.push_back(0); order_q.push_back(1);
      fork
         txn(0, 0, 1'b0, 3'd3, 3'd3, 16'h0, 16'h1234, 16'h1234, 3);
         txn(1, 0, 1'b0, 3'd3, 3'd0, 16'h0, 16'h1234, 16'h0000, 6);
      join
      order_q.push_back(0);
      txn(0, 0, 1'b0, 3'd0, 3'd3, 16'h0, 16'h0000, 16'h1234, 3);
      order_q.push_back(1); order_q.push_back(0);
      fork
         txn(0, 0, 1'b0, 3'd3, 3'd3, 16'h0, 16'h1234, 16'h1234, 6);
         txn(1, 0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0000, 16'h0000, 3);
      join

      // Protected register 0: acked but never written.
      we_seen = 1'b0;
      order_q.push_back(1);
      txn(1, 0, 1'b1, 3'd0, 3'd0, 16'hFFFF, 16'h0, 16'h0, 3);
      chk("r0_write_blocked", {127'h0, we_seen}, 128'h0);
      order_q.push_back(1);
      txn(1, 0, 1'b0, 3'd0, 3'd3, 16'h0, 16'h0000, 16'h1234, 3);

      // Read by 1 pending while 0 writes R5.
      order_q.push_back(0); order_q.push_back(1);
      fork
         txn(0, 0, 1'b1, 3'd5, 3'd0, 16'h00AB, 16'h0, 16'h0, 3);
         txn(1, 1, 1'b0, 3'd5, 3'd5, 16'h0, 16'h00AB, 16'h00AB, 5);
      join

      // Reset during ACESSO of a write.
      @(posedge clock); #1;
      wr_t[0] = 1'b1; sel_a_t[0] = 3'd6; wdata_t[0] = 16'hBEEF; req_t[0] = 1'b1;
      @(posedge clock); #1;
      chk("acesso_write_enable", {127'h0, Hab_Escrita}, 128'h1);
      #1 reset = 1'b0;
      #1 chk("reset_drops_write", {127'h0, Hab_Escrita}, 128'h0);
      req_t[0] = 1'b0;
      repeat (2) begin
         @(negedge clock);
         chk("reset_no_ack_gnt", {124'h0, gnt, ack}, 128'h0);
      end
      @(posedge clock); #1 reset = 1'b1;
      order_q.push_back(0); order_q.push_back(1);
      fork
         txn(0, 0, 1'b0, 3'd5, 3'd3, 16'h0, 16'h00AB, 16'h1234, 3);
         txn(1, 0, 1'b0, 3'd0, 3'd5, 16'h0, 16'h0000, 16'h00AB, 6);
      join

      repeat (3) @(posedge clock);
      chk("scoreboard_drained", order_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end
endmodule
